// File: rtl/serial_adder_pkg.sv
// Shared types and elaboration helpers for the slice-serial adder/subtractor.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int calc_nsteps(input int width, input int bpc);
        return width / bpc;
    endfunction

    // Step counter needs at least one bit even when a single step covers the word.
    function automatic int cnt_width(input int nsteps);
        return (nsteps > 1) ? $clog2(nsteps) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// Single-bit full adder; chained per slice by the serial adder.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: BITS_PER_CYCLE-bit ripple slice reused LSB-first
// across the operand, with valid/ready handshakes on both sides.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);
    localparam int NSTEPS = calc_nsteps(WIDTH, BITS_PER_CYCLE);
    localparam int CNT_W  = cnt_width(NSTEPS);

    if (WIDTH < 2) begin : g_bad_width
        $error("serial_adder: WIDTH must be at least 2");
    end
    if (WIDTH % BITS_PER_CYCLE != 0) begin : g_bad_bpc
        $error("serial_adder: BITS_PER_CYCLE must divide WIDTH");
    end

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic               carry_q, carry_d;
    logic               ovf_q, ovf_d;
    logic               ready_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    int                          slice_base;
    logic [BITS_PER_CYCLE-1:0]   slice_a, slice_b, slice_s;
    logic [BITS_PER_CYCLE:0]     chain;

    assign slice_base = int'(cnt_q) * BITS_PER_CYCLE;
    assign slice_a    = a_q[slice_base +: BITS_PER_CYCLE];
    assign slice_b    = b_q[slice_base +: BITS_PER_CYCLE];
    assign chain[0]   = carry_q;

    for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_chain
        fa_cell u_fa (
            .a    (slice_a[gi]),
            .b    (slice_b[gi]),
            .cin  (chain[gi]),
            .s    (slice_s[gi]),
            .cout (chain[gi+1])
        );
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        ovf_d     = ovf_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                // ready_q keeps in_ready low until the first edge after reset release.
                in_ready = ready_q;
                if (in_valid && ready_q) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : c_in;
                    cnt_d   = '0;
                    sum_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[slice_base +: BITS_PER_CYCLE] = slice_s;
                carry_d = chain[BITS_PER_CYCLE];
                if (cnt_q == CNT_W'(NSTEPS - 1)) begin
                    // Signed overflow: carry into the MSB differs from carry out of it.
                    ovf_d   = chain[BITS_PER_CYCLE] ^ chain[BITS_PER_CYCLE-1];
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            ready_q <= 1'b1;
        end
    end

    assign sum   = sum_q;
    assign c_out = carry_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and exhaustive checks of serial_adder across four width/slice configurations.
module tb_serial_adder;

    logic       clk;
    logic       rst_n;
    logic       in_valid  [4];
    logic       out_ready [4];
    logic       c_in      [4];
    logic       sub       [4];
    logic [7:0] a         [4];
    logic [7:0] b         [4];
    logic       in_ready  [4];
    logic       out_valid [4];
    logic       c_out     [4];
    logic       ovf       [4];
    logic [7:0] sum       [4];
    logic [3:0] sum2, sum3;

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 0: W8/B1, 1: W8/B2, 2: W4/B1, 3: W4/B4
    serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a[0]), .b(b[0]), .c_in(c_in[0]), .sub(sub[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .sum(sum[0]), .c_out(c_out[0]), .ovf(ovf[0]));
    serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a[1]), .b(b[1]), .c_in(c_in[1]), .sub(sub[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .sum(sum[1]), .c_out(c_out[1]), .ovf(ovf[1]));
    serial_adder #(.WIDTH(4), .BITS_PER_CYCLE(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .a(a[2][3:0]), .b(b[2][3:0]), .c_in(c_in[2]), .sub(sub[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .sum(sum2), .c_out(c_out[2]), .ovf(ovf[2]));
    serial_adder #(.WIDTH(4), .BITS_PER_CYCLE(4)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
        .a(a[3][3:0]), .b(b[3][3:0]), .c_in(c_in[3]), .sub(sub[3]), .out_valid(out_valid[3]),
        .out_ready(out_ready[3]), .sum(sum3), .c_out(c_out[3]), .ovf(ovf[3]));

    assign sum[2] = {4'h0, sum2};
    assign sum[3] = {4'h0, sum3};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Full transaction on instance d: accept, measure latency, check result, release.
    task automatic run_op(input int d, input logic [7:0] av, input logic [7:0] bv,
                          input logic cv, input logic sv, input int lat,
                          input logic [7:0] es, input logic ec, input logic eo,
                          input string tag);
        int cyc;
        @(negedge clk);
        a[d] = av; b[d] = bv; c_in[d] = cv; sub[d] = sv; in_valid[d] = 1'b1;
        check({tag, ".in_ready"}, in_ready[d], 1'b1);
        @(posedge clk);
        @(negedge clk);
        in_valid[d] = 1'b0;
        a[d] = ~av; b[d] = ~bv; c_in[d] = ~cv; sub[d] = ~sv;
        cyc = 0;
        while (!out_valid[d] && cyc < 64) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        check({tag, ".latency"}, cyc, lat);
        check({tag, ".sum"}, sum[d], es);
        check({tag, ".c_out"}, c_out[d], ec);
        check({tag, ".ovf"}, ovf[d], eo);
        $display("txn %s dut%0d a=%02h b=%02h cin=%0d sub=%0d -> sum=%02h c=%0d v=%0d lat=%0d",
                 tag, d, av, bv, cv, sv, sum[d], c_out[d], ovf[d], cyc);
        out_ready[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready[d] = 1'b0;
        check({tag, ".drop"}, out_valid[d], 1'b0);
        check({tag, ".hold"}, sum[d], es);
    endtask

    initial begin
        logic [4:0] full;
        logic [3:0] beff;
        logic       cin_eff, v;

        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid[i] = 1'b0; out_ready[i] = 1'b0; c_in[i] = 1'b0; sub[i] = 1'b0;
            a[i] = 8'h00; b[i] = 8'h00;
        end
        repeat (2) @(negedge clk);
        check("rst.in_ready", in_ready[0], 1'b0);
        check("rst.out_valid", out_valid[0], 1'b0);
        check("rst.sum", sum[0], 8'h00);
        check("rst.c_out", c_out[0], 1'b0);
        check("rst.ovf", ovf[0], 1'b0);
        rst_n = 1'b1;
        #1 check("rel.in_ready_low", in_ready[0], 1'b0);
        @(negedge clk);
        check("rel.in_ready_high", in_ready[0], 1'b1);

        run_op(0, 8'h5A, 8'h3C, 1'b0, 1'b0, 8, 8'h96, 1'b0, 1'b1, "add5A3C");
        run_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, 8, 8'h00, 1'b1, 1'b0, "addFF01");
        run_op(0, 8'hFF, 8'h01, 1'b1, 1'b0, 8, 8'h01, 1'b1, 1'b0, "addFF01c");
        run_op(1, 8'h10, 8'h20, 1'b0, 1'b1, 4, 8'hF0, 1'b0, 1'b0, "sub1020");
        run_op(1, 8'h80, 8'h01, 1'b0, 1'b1, 4, 8'h7F, 1'b1, 1'b1, "sub8001");

        // Backpressure: result held while a new request waits.
        @(negedge clk);
        a[0] = 8'h12; b[0] = 8'h34; c_in[0] = 1'b0; sub[0] = 1'b0; in_valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (8) @(negedge clk);
        check("bp.valid", out_valid[0], 1'b1);
        check("bp.sum", sum[0], 8'h46);
        a[0] = 8'h70; b[0] = 8'h20; in_valid[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp.hold_valid", out_valid[0], 1'b1);
            check("bp.hold_sum", sum[0], 8'h46);
            check("bp.hold_ready", in_ready[0], 1'b0);
        end
        out_ready[0] = 1'b1;
        @(negedge clk);
        out_ready[0] = 1'b0;
        check("bp.released", out_valid[0], 1'b0);
        check("bp.idle_ready", in_ready[0], 1'b1);
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        check("bp.busy", in_ready[0], 1'b0);
        repeat (7) @(negedge clk);
        check("bp2.not_early", out_valid[0], 1'b0);
        @(negedge clk);
        check("bp2.valid", out_valid[0], 1'b1);
        check("bp2.sum", sum[0], 8'h90);
        check("bp2.c_out", c_out[0], 1'b0);
        check("bp2.ovf", ovf[0], 1'b1);
        $display("txn backpressure dut0 12+34=46 then 70+20 -> sum=%02h", sum[0]);
        out_ready[0] = 1'b1;
        @(negedge clk);
        out_ready[0] = 1'b0;

        // Reset after three of eight steps.
        @(negedge clk);
        a[0] = 8'h5A; b[0] = 8'h3C; c_in[0] = 1'b0; sub[0] = 1'b0; in_valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("mid.partial_sum", sum[0], 8'h06);
        #2 rst_n = 1'b0;
        #1;
        check("mid.out_valid", out_valid[0], 1'b0);
        check("mid.sum", sum[0], 8'h00);
        check("mid.c_out", c_out[0], 1'b0);
        check("mid.in_ready", in_ready[0], 1'b0);
        $display("txn reset-abort dut0 sum=%02h", sum[0]);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid.rel_ready", in_ready[0], 1'b1);
        check("mid.rel_valid", out_valid[0], 1'b0);
        run_op(0, 8'h01, 8'h01, 1'b0, 1'b0, 8, 8'h02, 1'b0, 1'b0, "post_rst");

        // Exhaustive 4-bit sweep against a behavioural model.
        for (int d = 2; d < 4; d++) begin
            for (int m = 0; m < 1024; m++) begin
                logic [3:0] av, bv;
                logic       cv, sv;
                av = m[3:0]; bv = m[7:4]; cv = m[8]; sv = m[9];
                beff    = sv ? ~bv : bv;
                cin_eff = sv ? 1'b1 : cv;
                full    = {1'b0, av} + {1'b0, beff} + {4'b0, cin_eff};
                v       = (av[3] == beff[3]) && (full[3] != av[3]);
                run_op(d, {4'h0, av}, {4'h0, bv}, cv, sv, (d == 2) ? 4 : 1,
                       {4'h0, full[3:0]}, full[4], v, "exh");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
